rr_flit_scheduler: RTL and testbench

Synchronous three-requester round-robin scheduler that shares one router output path between three flit sources. Each source presents an 11-bit flit: bits [10:4] are data and bits [3:0] are the destination address. The block grants one requester per cycle and registers the winning flit into a single output holding stage. The output is already split into data and address fields, with a 2-bit source tag matching the merge select encoding (00, 01, 10). It sits between the per-port input queues and the output link driver, and it counts throughput and output back-pressure stalls.

---
 rtl/rr_flit_scheduler.sv | 131 +++++++++++++
 tb/tb_rr_flit_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_flit_scheduler.sv
// Three-requester round-robin flit scheduler feeding one output holding stage.
// The winning flit is registered, split into data/address fields, and tagged
// with its source index. Throughput and back-pressure stalls are counted.
module rr_flit_scheduler #(
    parameter int WIDTH       = 11,
    parameter int STALL_LIMIT = 8,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           in_valid,
    input  logic [3*WIDTH-1:0]   in_flit,
    output logic [2:0]           in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-5:0]     out_data,
    output logic [3:0]           out_addr,
    output logic [1:0]           out_src,
    output logic [CNT_W-1:0]     flit_count,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic                 stall_flag
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e               state_q, state_d;
    logic [1:0]           rr_ptr_q, rr_ptr_d;
    logic [WIDTH-5:0]     data_q;
    logic [3:0]           addr_q;
    logic [1:0]           src_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [CNT_W-1:0]     stall_q, stall_d;
    logic                 flag_q;

    logic [1:0]           ptr_eff;
    logic                 can_load;
    logic [1:0]           cand;
    logic [1:0]           win_idx;
    logic                 win_found;
    logic                 accept;
    logic [WIDTH-1:0]     sel_flit;

    // Reduce a 0..5 sum to 0..2.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Round-robin search starting at rr_ptr; an illegal pointer of 3 acts as 0.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        win_idx   = 2'd0;
        win_found = 1'b0;
        cand      = 2'd0;
        ptr_eff   = (rr_ptr_q == 2'd3) ? 2'd0 : rr_ptr_q;
        can_load  = (state_q == EMPTY) || out_ready;
        for (int k = 0; k < 3; k++) begin
            cand = wrap3({1'b0, ptr_eff} + 3'(k));
            if (!win_found && in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        // Grants are suppressed while reset is held, even though state is already cleared.
        in_ready = (can_load && win_found && !reset) ? (3'b001 << win_idx) : 3'b000;
        accept   = |in_ready;
        sel_flit = in_flit[win_idx*WIDTH +: WIDTH];
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of block ordering.
        else       state_q <= state_d;
    end

    // FSM next state: load wins over drain, so drain+accept stays FULL.
    always_comb begin
        state_d = state_q;
        if (accept)                              state_d = FULL;
        else if (state_q == FULL && out_ready)   state_d = EMPTY;
    end

    // FSM outputs.
    always_comb begin
        out_valid = (state_q == FULL);
    end

    // Next-state values for pointer and counters.
    always_comb begin
        rr_ptr_d = accept ? wrap3({1'b0, win_idx} + 3'd1) : ptr_eff;
        count_d  = count_q + CNT_W'(accept);
        stall_d  = stall_q;
        if (state_q == FULL) begin
            if (!out_ready) stall_d = (stall_q == {CNT_W{1'b1}}) ? stall_q : stall_q + 1'b1;
            else            stall_d = '0;
        end
    end

    // Holding register, pointer and counters; reset discards any held flit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= 2'd0;
            data_q   <= '0;
            addr_q   <= '0;
            src_q    <= 2'd0;
            count_q  <= '0;
            stall_q  <= '0;
            flag_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            flag_q   <= (stall_d >= CNT_W'(STALL_LIMIT));
            if (accept) begin
                data_q <= sel_flit[WIDTH-1:4];
                addr_q <= sel_flit[3:0];
                src_q  <= win_idx;
            end
        end
    end

    assign out_data   = data_q;
    assign out_addr   = addr_q;
    assign out_src    = src_q;
    assign flit_count = count_q;
    assign stall_cnt  = stall_q;
    assign stall_flag = flag_q;

endmodule

// File: tb/tb_rr_flit_scheduler.sv
// Scoreboard bench for rr_flit_scheduler: a reference model predicts grants,
// queues the expected output flits and tracks counters; a second instance with
// 4-bit counters shares the stimulus to exercise flit_count wrap.
module tb_rr_flit_scheduler;

    localparam int WIDTH = 11;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       in_valid;
    logic [3*WIDTH-1:0] in_flit;
    logic             out_ready;

    logic [2:0]       in_ready, w_in_ready;
    logic             out_valid, w_out_valid;
    logic [6:0]       out_data, w_out_data;
    logic [3:0]       out_addr, w_out_addr;
    logic [1:0]       out_src, w_out_src;
    logic [15:0]      flit_count, stall_cnt;
    logic [3:0]       w_flit_count, w_stall_cnt;
    logic             stall_flag, w_stall_flag;

    rr_flit_scheduler #(.WIDTH(WIDTH), .STALL_LIMIT(8), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .out_src(out_src),
        .flit_count(flit_count), .stall_cnt(stall_cnt), .stall_flag(stall_flag)
    );

    rr_flit_scheduler #(.WIDTH(WIDTH), .STALL_LIMIT(8), .CNT_W(4)) u_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit),
        .in_ready(w_in_ready), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_data(w_out_data), .out_addr(w_out_addr), .out_src(w_out_src),
        .flit_count(w_flit_count), .stall_cnt(w_stall_cnt), .stall_flag(w_stall_flag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] src;
        logic [6:0] data;
        logic [3:0] addr;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr, m_count, m_stall, last_grant;
    bit          m_full, m_flag;
    logic [10:0] flits[3];

    task automatic reset_model();
        m_ptr = 0; m_count = 0; m_stall = 0; m_full = 0; m_flag = 0;
        last_grant = -1;
        sb.delete();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 3'b000; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        reset_model();
    endtask

    // One cycle: drive at negedge, compare registered outputs and grant, advance model.
    task automatic drive_cycle(input logic [2:0] v, input logic rdy);
        int w;
        logic [2:0] exp_ready;
        exp_t got;
        @(negedge clk);
        in_valid  = v;
        out_ready = rdy;
        in_flit   = {flits[2], flits[1], flits[0]};
        #1;
        n_checks++;
        if (out_valid !== m_full) begin
            n_fail++; $display("FAIL out_valid: got %b want %b", out_valid, m_full);
        end
        if (m_full) begin
            got = {out_src, out_data, out_addr};
            n_checks++;
            if (sb.size() == 0 || got !== sb[0]) begin
                n_fail++; $display("FAIL out_flit: got %h want %h", got, (sb.size() > 0) ? sb[0] : exp_t'(0));
            end
        end
        n_checks++;
        if (flit_count !== 16'(m_count)) begin
            n_fail++; $display("FAIL flit_count: got %0d want %0d", flit_count, m_count);
        end
        n_checks++;
        if (w_flit_count !== 4'(m_count)) begin
            n_fail++; $display("FAIL flit_count_w4: got %0d want %0d", w_flit_count, m_count % 16);
        end
        n_checks++;
        if (stall_cnt !== 16'(m_stall)) begin
            n_fail++; $display("FAIL stall_cnt: got %0d want %0d", stall_cnt, m_stall);
        end
        n_checks++;
        if (stall_flag !== m_flag) begin
            n_fail++; $display("FAIL stall_flag: got %b want %b", stall_flag, m_flag);
        end
        w = -1;
        if (!m_full || rdy)
            for (int k = 0; k < 3; k++)
                if (w < 0 && v[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        exp_ready = (w >= 0) ? 3'(1 << w) : 3'b000;
        n_checks++;
        if (in_ready !== exp_ready) begin
            n_fail++; $display("FAIL in_ready: got %b want %b", in_ready, exp_ready);
        end
        last_grant = w;
        if (m_full) begin
            if (rdy) begin
                m_stall = 0;
                if (sb.size() > 0) void'(sb.pop_front());
            end else if (m_stall < 65535) begin
                m_stall++;
            end
        end
        m_flag = (m_stall >= 8);
        if (w >= 0) begin
            sb.push_back({2'(w), flits[w][10:4], flits[w][3:0]});
            m_ptr  = (w + 1) % 3;
            m_count++;
            m_full = 1;
            flits[w] = 11'($urandom);
        end else if (m_full && rdy) begin
            m_full = 0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        drive_cycle(3'b001, 1'b0);
        repeat (3) drive_cycle(3'b000, 1'b0);
        @(negedge clk);
        #2;
        reset = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
        n_checks++;
        if (flit_count !== 16'd0) begin n_fail++; $display("FAIL rst_flit_count: got %0d want 0", flit_count); end
        n_checks++;
        if (in_ready !== 3'b000) begin n_fail++; $display("FAIL rst_in_ready: got %b want 000", in_ready); end
        @(negedge clk);
        reset = 1'b0; in_valid = 3'b000;
        reset_model();
        drive_cycle(3'b111, 1'b1);
        n_checks++;
        if (last_grant != 0 || in_ready !== 3'b001) begin
            n_fail++; $display("FAIL rst_ptr: got grant %b want 001", in_ready);
        end
        drive_cycle(3'b000, 1'b1);
    endtask

    task automatic test_single();
        apply_reset();
        flits[0] = 11'b1010101_0110;
        drive_cycle(3'b001, 1'b1);
        drive_cycle(3'b000, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 7'b1010101 || out_addr !== 4'b0110 ||
            out_src !== 2'b00 || flit_count !== 16'd1) begin
            n_fail++;
            $display("FAIL single: got v=%b d=%b a=%b s=%b c=%0d want v=1 d=1010101 a=0110 s=00 c=1",
                     out_valid, out_data, out_addr, out_src, flit_count);
        end
    endtask

    task automatic test_all_three();
        int want[6] = '{0, 1, 2, 0, 1, 2};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(3'b111, 1'b1);
            n_checks++;
            if (last_grant != want[i]) begin
                n_fail++; $display("FAIL rr3_grant[%0d]: got in_ready %b want index %0d", i, in_ready, want[i]);
            end
        end
        drive_cycle(3'b000, 1'b1);
        n_checks++;
        if (flit_count !== 16'd6) begin n_fail++; $display("FAIL rr3_count: got %0d want 6", flit_count); end
        drive_cycle(3'b000, 1'b1);
    endtask

    task automatic test_two_requesters();
        int want[4] = '{1, 2, 1, 2};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(3'b110, 1'b1);
            n_checks++;
            if (last_grant != want[i] || in_ready[0] !== 1'b0) begin
                n_fail++; $display("FAIL rr2_grant[%0d]: got in_ready %b want index %0d", i, in_ready, want[i]);
            end
        end
        drive_cycle(3'b000, 1'b1);
        drive_cycle(3'b000, 1'b1);
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive_cycle(3'b001, 1'b1);
        repeat (10) drive_cycle(3'b010, 1'b0);
        drive_cycle(3'b010, 1'b1);
        n_checks++;
        if (stall_cnt !== 16'd10 || stall_flag !== 1'b1 || in_ready !== 3'b010) begin
            n_fail++; $display("FAIL bp_peak: got cnt=%0d flag=%b rdy=%b want cnt=10 flag=1 rdy=010",
                               stall_cnt, stall_flag, in_ready);
        end
        drive_cycle(3'b000, 1'b1);
        n_checks++;
        if (stall_cnt !== 16'd0 || stall_flag !== 1'b0) begin
            n_fail++; $display("FAIL bp_clear: got cnt=%0d flag=%b want cnt=0 flag=0", stall_cnt, stall_flag);
        end
        drive_cycle(3'b000, 1'b1);
    endtask

    task automatic test_wrap();
        apply_reset();
        repeat (17) drive_cycle(3'b001, 1'b1);
        drive_cycle(3'b000, 1'b1);
        n_checks++;
        if (w_flit_count !== 4'd1 || flit_count !== 16'd17) begin
            n_fail++; $display("FAIL wrap: got w4=%0d w16=%0d want w4=1 w16=17", w_flit_count, flit_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 3'b000;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) flits[i] = 11'($urandom);
        in_flit   = {flits[2], flits[1], flits[0]};
        reset_model();
        test_reset();
        test_single();
        test_all_three();
        test_two_requesters();
        test_backpressure();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
